hilo_seq_unit: RTL and testbench

- Sequential HI/LO execution and storage unit for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from the pipeline.
- Division runs iteratively over multiple cycles, one quotient bit per cycle. Results are committed into architectural HI/LO registers.
- Serves MFHI/MFLO reads, and tells the pipeline to stall while a divide is in flight.
- It is the consumer/holder end of the HI/LO path: results are written and later read back through it.

---
 rtl/hilo_seq_unit_if.sv | 38 +++
 rtl/hilo_seq_unit.sv | 171 +++++++++++++++++
 tb/tb_hilo_seq_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_seq_unit_if.sv
// hilo_seq_unit_if
//   Issue, read and status bundle between the EX-stage pipeline and the
//   HI/LO execution unit.
//   Ports (slave = unit side):
//     valid_i   issue strobe
//     ctrl_i    5-bit op code
//     a_i, b_i  operands
//     cancel_i  exception flush
//     rd_sel_i  read select, 0=LO 1=HI
//     rd_data_o selected register (combinational)
//     hi_o/lo_o architectural HI/LO
//     busy_o    divide in flight
//     done_o    one-cycle pulse after a MULT/DIV result lands
interface hilo_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [4:0]       ctrl_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             rd_sel_i;
    logic [WIDTH-1:0] rd_data_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output valid_i, ctrl_i, a_i, b_i, cancel_i, rd_sel_i,
        input  rd_data_o, hi_o, lo_o, busy_o, done_o
    );

    modport slave (
        input  valid_i, ctrl_i, a_i, b_i, cancel_i, rd_sel_i,
        output rd_data_o, hi_o, lo_o, busy_o, done_o
    );
endinterface

// File: rtl/hilo_seq_unit.sv
// hilo_seq_unit
//   Sequential HI/LO unit for the EX stage. MULT/MULTU complete at the
//   accepting edge; DIV/DIVU run a restoring divider (one quotient bit per
//   cycle) followed by a sign-fix cycle; MTHI/MTLO write directly.
//   Ports:
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset
//     bus     hilo_seq_unit_if.slave (issue, read and status signals)
//   Op codes: MULTU=01000 MULT=01001 DIVU=01010 DIV=01011
//             MTHI=10100 MTLO=10101, anything else is a no-op.
module hilo_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            resetn,
    hilo_seq_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_FIX
    } state_e;

    typedef enum logic [4:0] {
        OP_MULTU = 5'b01000,
        OP_MULT  = 5'b01001,
        OP_DIVU  = 5'b01010,
        OP_DIV   = 5'b01011,
        OP_MTHI  = 5'b10100,
        OP_MTLO  = 5'b10101
    } op_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in
    // at the LSB, so after the last iteration this register is the quotient.
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic             qneg_q,  qneg_d;
    logic             rneg_q,  rneg_d;
    logic             done_q,  done_d;

    logic               accept;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;

        // cancel on the same cycle as an issue drops the op
        accept    = bus.valid_i && !bus.cancel_i && (state_q == ST_IDLE);
        is_signed = bus.ctrl_i[0];
        a_neg     = is_signed && bus.a_i[WIDTH-1];
        b_neg     = is_signed && bus.b_i[WIDTH-1];
        a_mag     = a_neg ? -bus.a_i : bus.a_i;
        b_mag     = b_neg ? -bus.b_i : bus.b_i;
        prod      = {{WIDTH{a_neg}}, bus.a_i} * {{WIDTH{b_neg}}, bus.b_i};

        partial   = {rem_q, quo_q[WIDTH-1]};
        diff      = partial - {1'b0, dvs_q};

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(bus.ctrl_i))
                        OP_MULTU, OP_MULT: begin
                            {hi_d, lo_d} = prod;
                            done_d       = 1'b1;
                        end
                        OP_DIVU, OP_DIV: begin
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            rem_d   = '0;
                            cnt_d   = '0;
                            // A zero divisor must leave the all-ones raw
                            // quotient untouched, so its sign fix is suppressed.
                            qneg_d  = (a_neg ^ b_neg) && (|bus.b_i);
                            rneg_d  = a_neg;
                            state_d = ST_DIV;
                        end
                        OP_MTHI: hi_d = bus.a_i;
                        OP_MTLO: lo_d = bus.a_i;
                        default: ;
                    endcase
                end
            end

            ST_DIV: begin
                if (bus.cancel_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // restoring step: keep the difference only if non-negative
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = partial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.cancel_i) begin
                    lo_d   = qneg_q ? -quo_q : quo_q;
                    hi_d   = rneg_q ? -rem_q : rem_q;
                    done_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.done_o    = done_q;
    assign bus.rd_data_o = bus.rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_seq_unit.sv
module tb_hilo_seq_unit;

    localparam logic [4:0] C_MULTU = 5'b01000;
    localparam logic [4:0] C_MULT  = 5'b01001;
    localparam logic [4:0] C_DIVU  = 5'b01010;
    localparam logic [4:0] C_DIV   = 5'b01011;
    localparam logic [4:0] C_MTHI  = 5'b10100;
    localparam logic [4:0] C_MTLO  = 5'b10101;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    hilo_seq_unit_if #(.WIDTH(32)) bus();

    hilo_seq_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural reference: plain integer arithmetic on {HI,LO}.
    function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            C_MULTU: p = 64'(a) * 64'(b);
            C_MULT:  p = sa * sb;
            C_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            C_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            C_MTHI:  p = {a, lo};
            C_MTLO:  p = {hi, a};
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done_o pulse must match the oldest pending result.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus.done_o === 1'b1) begin
                chk("done_has_expect", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("done_hilo", {bus.hi_o, bus.lo_o}, mon_e);
                    chk("done_rd_data", 64'(bus.rd_data_o),
                        64'(bus.rd_sel_i ? mon_e[63:32] : mon_e[31:0]));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(bus.busy_o), 64'd0);
    endtask

    // Drive one issue cycle; returns just after the accepting edge.
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    // Full op with optional cancel after cancel_at DIV/FIX cycles (-1 = none).
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at);
        logic [63:0] r;
        bit is_div;
        int n;
        wait_idle();
        is_div = (op == C_DIV) || (op == C_DIVU);
        r = ref_op(op, a, b, m_hi, m_lo);
        if (!(is_div && cancel_at >= 0)) begin
            if (is_div || op == C_MULT || op == C_MULTU) exp_q.push_back(r);
            {m_hi, m_lo} = r;
        end
        start_op(op, a, b);
        if (is_div) begin
            if (cancel_at >= 0) begin
                repeat (cancel_at) @(posedge clk);
                #1 bus.cancel_i = 1'b1;
                @(posedge clk); #1;
                bus.cancel_i = 1'b0;
                chk("cancel_busy", 64'(bus.busy_o), 64'd0);
                chk("cancel_hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
            end else begin
                n = 0;
                while (bus.busy_o === 1'b1 && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("div_busy_cycles", 64'(n), 64'd33);
            end
        end else begin
            chk("nodiv_busy", 64'(bus.busy_o), 64'd0);
            chk("op_hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
        end
    endtask

    initial begin
        logic [63:0] hold;
        logic [4:0] ops[8];
        logic [4:0] op;
        ops = '{C_MULTU, C_MULT, C_DIVU, C_DIV, C_MTHI, C_MTLO, 5'b00000, 5'b11111};

        bus.valid_i  = 1'b0;
        bus.ctrl_i   = '0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.cancel_i = 1'b0;
        bus.rd_sel_i = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_done", 64'(bus.done_o), 64'd0);

        // directed cases
        do_op(C_MULT,  32'hFFFF_FFFE, 32'h3, -1);
        do_op(C_MULTU, 32'hFFFF_FFFE, 32'h3, -1);
        chk("multu_hand", {m_hi, m_lo}, 64'h0000_0002_FFFF_FFFA);
        do_op(C_DIV,   32'hFFFF_FFF9, 32'd2, -1);
        do_op(C_DIVU,  32'd100, 32'd7, -1);
        do_op(C_DIVU,  32'h1234_5678, 32'd0, -1);
        do_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(C_MTHI,  32'h1111_1111, 32'd0, -1);
        do_op(C_MTLO,  32'h1111_1111, 32'd0, -1);
        do_op(C_MTHI,  32'hDEAD_BEEF, 32'd0, -1);
        bus.rd_sel_i = 1'b1;
        @(negedge clk);
        chk("rd_hi", 64'(bus.rd_data_o), 64'h0000_0000_DEAD_BEEF);
        bus.rd_sel_i = 1'b0;
        @(negedge clk);
        chk("rd_lo", 64'(bus.rd_data_o), 64'h0000_0000_1111_1111);

        // cancel during DIV cycle 5
        do_op(C_DIVU, 32'd100, 32'd7, 5);

        // issue while busy is ignored
        hold = {m_hi, m_lo};
        {m_hi, m_lo} = ref_op(C_DIVU, 32'd1000, 32'd9, m_hi, m_lo);
        exp_q.push_back({m_hi, m_lo});
        start_op(C_DIVU, 32'd1000, 32'd9);
        repeat (3) @(posedge clk);
        start_op(C_MULT, 32'h7, 32'h9);
        chk("busy_issue_ignored", {bus.hi_o, bus.lo_o}, hold);
        wait_idle();

        // cancel together with valid in IDLE drops the op
        @(posedge clk); #1;
        bus.cancel_i = 1'b1;
        start_op(C_MTLO, 32'hCAFE_F00D, 32'd0);
        bus.cancel_i = 1'b0;
        chk("cancel_idle_drop", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            bus.rd_sel_i = 1'($urandom_range(0, 1));
            if ((op == C_DIV || op == C_DIVU) && $urandom_range(0, 4) == 0)
                do_op(op, pick_operand(), pick_operand(), int'($urandom_range(0, 32)));
            else
                do_op(op, pick_operand(), pick_operand(), -1);
        end
        wait_idle();
        repeat (3) @(posedge clk);

        // async reset at DIV cycle 10
        exp_q.push_back(ref_op(C_DIV, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo));
        start_op(C_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        chk("midreset_busy", 64'(bus.busy_o), 64'd0);
        chk("midreset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
